// File: rtl/fft_output_reader_if.sv
// Output stream of the FFT unload block: one frequency sample per valid/ready transfer.
interface fft_output_reader_if #(
    parameter int unsigned DW = 16
);
    logic            m_valid;
    logic            m_ready;
    logic [2*DW-1:0] m_data;
    logic [5:0]      m_index;
    logic            m_last;

    modport master (output m_valid, output m_data, output m_index, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_index, input m_last, output m_ready);
endinterface

// File: rtl/fft_output_reader.sv
// Unloads a finished 64-point FFT frame from the two SRAM banks and streams it out.
// Define FFT_OUT_BITREV_EN to read in bit-reversed position order (natural frequency order out).
module fft_output_reader #(
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 re_b0,
    output logic [4:0]           raddr_b0,
    input  logic [2*DW-1:0]      rdata_b0,
    output logic                 re_b1,
    output logic [4:0]           raddr_b1,
    input  logic [2*DW-1:0]      rdata_b1,
    fft_output_reader_if.master  stream
);

    localparam int unsigned FDEPTH = RD_LAT + 2;
    localparam int unsigned WW     = 2 * DW;
    localparam int unsigned CW     = $clog2(FDEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [6:0]  k, k_nxt;
    logic        busy_nxt, done_nxt;
    logic        issue, credit, pop, push;
    logic [5:0]  pos, idx_iss;
    logic        bank_iss;
    logic        re_b0_nxt, re_b1_nxt;
    logic [4:0]  raddr_b0_nxt, raddr_b1_nxt;

    // Tag pipeline; stage 0 is aligned with the registered read enables.
    logic [RD_LAT:0]       tag_vld;
    logic [RD_LAT:0]       tag_bank;
    logic [RD_LAT:0][5:0]  tag_idx;

    // Shift FIFO: entry 0 is the head and drives the stream directly.
    logic [FDEPTH-1:0]          f_vld;
    logic [FDEPTH-1:0]          f_last;
    logic [FDEPTH-1:0][WW-1:0]  f_data;
    logic [FDEPTH-1:0][5:0]     f_idx;
    logic [CW-1:0]              occ, wr_slot;
    logic [CW-1:0]              cnt;
    logic [WW-1:0]              push_data;

    function automatic logic [5:0] bitrev6(input logic [5:0] x);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = x[5-i];
        return r;
    endfunction

    assign pop       = f_vld[0] & stream.m_ready;
    assign push      = tag_vld[RD_LAT];
    assign push_data = tag_bank[RD_LAT] ? rdata_b1 : rdata_b0;
    // cnt = FIFO occupancy + reads in flight; a pop this cycle frees its slot for this issue.
    assign credit    = (cnt < CW'(FDEPTH)) | pop;

    assign stream.m_valid = f_vld[0];
    assign stream.m_data  = f_data[0];
    assign stream.m_index = f_idx[0];
    assign stream.m_last  = f_last[0];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                    k_nxt     = '0;
                    busy_nxt  = 1'b1;
                end
            end
            READ: begin
                if (credit && !k[6]) begin
                    issue = 1'b1;
                    k_nxt = 7'(k + 7'd1);
                    if (k[5:0] == 6'd63) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && f_last[0] && cnt == CW'(1)) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory position, bank and address for the read being issued.
    always_comb begin
`ifdef FFT_OUT_BITREV_EN
        pos = bitrev6(k[5:0]);
`else
        pos = k[5:0];
`endif
        bank_iss     = ^pos;
        idx_iss      = bitrev6(pos);
        re_b0_nxt    = issue & ~bank_iss;
        re_b1_nxt    = issue & bank_iss;
        raddr_b0_nxt = re_b0_nxt ? pos[5:1] : 5'd0;
        raddr_b1_nxt = re_b1_nxt ? pos[5:1] : 5'd0;
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < int'(FDEPTH); i++) occ = occ + CW'(f_vld[i]);
        wr_slot = occ - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            re_b0    <= 1'b0;
            re_b1    <= 1'b0;
            raddr_b0 <= '0;
            raddr_b1 <= '0;
            tag_vld  <= '0;
            tag_bank <= '0;
            tag_idx  <= '0;
            cnt      <= '0;
        end else begin
            re_b0       <= re_b0_nxt;
            re_b1       <= re_b1_nxt;
            raddr_b0    <= raddr_b0_nxt;
            raddr_b1    <= raddr_b1_nxt;
            tag_vld[0]  <= issue;
            tag_bank[0] <= bank_iss;
            tag_idx[0]  <= idx_iss;
            for (int j = 1; j <= int'(RD_LAT); j++) begin
                tag_vld[j]  <= tag_vld[j-1];
                tag_bank[j] <= tag_bank[j-1];
                tag_idx[j]  <= tag_idx[j-1];
            end
            cnt <= cnt + CW'(issue) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            f_vld  <= '0;
            f_last <= '0;
            f_data <= '0;
            f_idx  <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < int'(FDEPTH) - 1; i++) begin
                    f_vld[i]  <= f_vld[i+1];
                    f_last[i] <= f_last[i+1];
                    f_data[i] <= f_data[i+1];
                    f_idx[i]  <= f_idx[i+1];
                end
                f_vld[FDEPTH-1]  <= 1'b0;
                f_last[FDEPTH-1] <= 1'b0;
            end
            if (push) begin
                f_vld[wr_slot]  <= 1'b1;
                f_last[wr_slot] <= (tag_idx[RD_LAT] == 6'd63);
                f_data[wr_slot] <= push_data;
                f_idx[wr_slot]  <= tag_idx[RD_LAT];
            end
        end
    end

endmodule
